// File: rtl/spi_regif.sv
// SPI-slave register interface: decodes 16-bit mode-0 frames into one-clock load
// strobes and a held write byte, and shifts readback data out on miso.
`timescale 1ns/1ps
module spi_regif (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sclk,
  input  logic       ssn,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] configrdreg0,
  input  logic [7:0] configrdreg1,
  input  logic [7:0] configrdreg2,
  input  logic [7:0] controlrdata,
  input  logic [7:0] hwconfig,
  output logic       cfgld0,
  output logic       cfgld1,
  output logic       cfgld2,
  output logic       ctrlld,
  output logic       wdogdivld,
  output logic       wdreset,
  output logic [7:0] wrtdata,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic [1:0] r_sclk_sync;
  logic [1:0] r_ssn_sync;
  logic [1:0] r_mosi_sync;
  logic       r_sclk_prev;
  logic       r_ssn_prev;

  logic [3:0] r_bit_cnt;
  logic [6:0] r_shift_in;
  logic [7:0] r_shift_out;
  logic       r_rnw;
  logic [3:0] r_addr;

  logic       r_cfgld0;
  logic       r_cfgld1;
  logic       r_cfgld2;
  logic       r_ctrlld;
  logic       r_wdogdivld;
  logic       r_wdreset;
  logic [7:0] r_wrtdata;

  logic       w_sclk;
  logic       w_ssn;
  logic       w_mosi;
  logic       w_rise;
  logic       w_fall;
  logic       w_ssn_fall;
  logic       w_active;
  logic [7:0] w_byte;
  logic       w_cmd_done;
  logic       w_data_done;
  logic [7:0] w_rdback;

  // ssn sync resets low so a frame already in progress at reset release is not
  // mistaken for a new one; only a real high->low transition starts a frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sclk_sync <= 2'b00;
      r_ssn_sync  <= 2'b00;
      r_mosi_sync <= 2'b00;
      r_sclk_prev <= 1'b0;
      r_ssn_prev  <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], sclk};
      r_ssn_sync  <= {r_ssn_sync[0], ssn};
      r_mosi_sync <= {r_mosi_sync[0], mosi};
      r_sclk_prev <= r_sclk_sync[1];
      r_ssn_prev  <= r_ssn_sync[1];
    end
  end

  assign w_sclk      = r_sclk_sync[1];
  assign w_ssn       = r_ssn_sync[1];
  assign w_mosi      = r_mosi_sync[1];
  assign w_rise      = w_sclk & ~r_sclk_prev;
  assign w_fall      = ~w_sclk & r_sclk_prev;
  assign w_ssn_fall  = ~w_ssn & r_ssn_prev;
  assign w_active    = (r_state == ST_CMD) || (r_state == ST_DATA);
  assign w_byte      = {r_shift_in, w_mosi};
  assign w_cmd_done  = (r_state == ST_CMD) && w_rise && (r_bit_cnt == 4'd7);
  assign w_data_done = (r_state == ST_DATA) && w_rise && (r_bit_cnt == 4'd15);

  always_comb begin
    w_rdback = 8'h00;
    case (w_byte[3:0])
      4'd0:    w_rdback = configrdreg0;
      4'd1:    w_rdback = configrdreg1;
      4'd2:    w_rdback = configrdreg2;
      4'd3:    w_rdback = controlrdata;
      4'd5:    w_rdback = hwconfig;
      default: w_rdback = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ssn high always wins, which both ends a finished frame and aborts a partial one.
  always_comb begin
    w_next = r_state;
    if (w_ssn) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_ssn_fall)  w_next = ST_CMD;
        ST_CMD:  if (w_cmd_done)  w_next = ST_DATA;
        ST_DATA: if (w_data_done) w_next = ST_DONE;
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    miso      = (r_state == ST_DATA) & r_shift_out[7];
    dbg_state = r_state;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bit_cnt   <= 4'd0;
      r_shift_in  <= 7'd0;
      r_shift_out <= 8'h00;
      r_rnw       <= 1'b0;
      r_addr      <= 4'd0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_bit_cnt <= 4'd0;
      end else if (w_active && w_rise) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      if (w_active && w_rise) begin
        r_shift_in <= w_byte[6:0];
      end
      // The falling edge right after the command byte does not shift, so bit7
      // of the readback sits on miso before the first data rising edge.
      if (w_cmd_done) begin
        r_rnw  <= w_byte[7];
        r_addr <= w_byte[3:0];
        if (w_byte[7]) begin
          r_shift_out <= w_rdback;
        end
      end else if ((r_state == ST_DATA) && w_fall && (r_bit_cnt != 4'd8)) begin
        r_shift_out <= {r_shift_out[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cfgld0    <= 1'b0;
      r_cfgld1    <= 1'b0;
      r_cfgld2    <= 1'b0;
      r_ctrlld    <= 1'b0;
      r_wdogdivld <= 1'b0;
      r_wdreset   <= 1'b0;
      r_wrtdata   <= 8'h00;
    end else begin
      r_cfgld0    <= 1'b0;
      r_cfgld1    <= 1'b0;
      r_cfgld2    <= 1'b0;
      r_ctrlld    <= 1'b0;
      r_wdogdivld <= 1'b0;
      r_wdreset   <= 1'b0;
      if (w_data_done && !r_rnw) begin
        case (r_addr)
          4'd0: begin r_cfgld0    <= 1'b1; r_wrtdata <= w_byte; end
          4'd1: begin r_cfgld1    <= 1'b1; r_wrtdata <= w_byte; end
          4'd2: begin r_cfgld2    <= 1'b1; r_wrtdata <= w_byte; end
          4'd3: begin r_ctrlld    <= 1'b1; r_wrtdata <= w_byte; end
          4'd4: begin r_wdogdivld <= 1'b1; r_wrtdata <= w_byte; end
          4'd6: r_wdreset <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign cfgld0    = r_cfgld0;
  assign cfgld1    = r_cfgld1;
  assign cfgld2    = r_cfgld2;
  assign ctrlld    = r_ctrlld;
  assign wdogdivld = r_wdogdivld;
  assign wdreset   = r_wdreset;
  assign wrtdata   = r_wrtdata;

endmodule

// File: doc/spi_regif.md
# spi_regif

SPI-slave register interface that lets the host microcontroller configure and supervise the motor control block. Decodes 16-bit SPI frames into one-clock load strobes (`cfgld0..2`, `ctrlld`, `wdogdivld`) plus a stable `wrtdata` byte, and returns readback data on `miso`. Also turns host "kick" writes into one-clock `wdreset` pulses for the watchdog. Sits between the external SPI pins and the control block; everything runs on the system clock, and SCLK is sampled as data.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `sclk` in 1: SPI clock, asynchronous to `clk`; mode 0.
- `ssn` in 1: SPI select, active-low, asynchronous.
- `mosi` in 1: SPI data in, MSB first.
- `miso` out 1: SPI data out, MSB first; driven low when not selected.
- `configrdreg0`, `configrdreg1`, `configrdreg2` in 8: config readback.
- `controlrdata` in 8: control register readback.
- `hwconfig` in 8: hardware configuration readback.
- `cfgld0`, `cfgld1`, `cfgld2`, `ctrlld`, `wdogdivld` out 1: one-clock write strobes.
- `wdreset` out 1: one-clock watchdog kick pulse.
- `wrtdata` out 8: write data; valid with the strobe and held until the next write.

## Operation
- **Input synchronisation.** `sclk`, `ssn` and `mosi` each pass through a 2-FF synchroniser. Edges are detected from the synchronised `sclk` (current vs previous sample).
- **Frame format.** A frame is 16 SCLK rising edges while `ssn` is low.
  - Command byte: bit7 = R/nW (1 = read), bits6:4 ignored, bits3:0 = address.
  - Data byte: write data (write) or don't-care (read).
- **Address map** (R readback / W action):
  - 0: `configrdreg0` / `cfgld0`.
  - 1: `configrdreg1` / `cfgld1`.
  - 2: `configrdreg2` / `cfgld2`.
  - 3: `controlrdata` / `ctrlld`.
  - 4: 0x00 / `wdogdivld`.
  - 5: `hwconfig` / no action.
  - 6: 0x00 / `wdreset` pulse, data ignored.
  - 7–15: 0x00 / no action.
- **FSM states:**
  - IDLE: `ssn` high. Bit counter = 0, `miso` = 0.
  - CMD: entered when `ssn` goes low. Shift `mosi` in on each SCLK rising edge. After the 8th rising edge, latch R/nW and address; for reads, load the readback byte into the output shift register; go to DATA.
  - DATA: shift `mosi` in on rising edges 9–16. After the 16th rising edge, go to DONE; for writes, issue the strobe.
  - DONE: ignore further SCLK edges. Return to IDLE when `ssn` goes high.
- **Read path.**
  - `miso` = bit7 of the output shift register while in DATA.
  - The register shifts left on SCLK falling edges 9–15. The 8th falling edge does not shift, so bit7 is valid before the 9th rising edge.
  - `miso` = 0 in IDLE, CMD and DONE.
  - The readback value is captured once, at the 8th rising edge. Source changes later in the frame are not reflected.
- **Write path.**
  - The strobe for the decoded address is exactly one clock wide.
  - `wrtdata` updates in the same cycle as the strobe.
  - At most one strobe per frame. Reads generate no strobes.
- **Boundary conditions.**
  - `ssn` rising before the 16th edge aborts the frame: no strobe, counter cleared, state IDLE.
  - `ssn` falling again starts a new frame cleanly.
  - More than 16 SCLK edges: the extra edges are ignored in DONE.
  - SCLK edges while `ssn` is high are ignored.
  - A frame in progress when `resetn` is asserted is discarded. After release, the block waits in IDLE; a frame already in progress is treated as new only after an `ssn` high→low transition.

## Timing
- **Reset values:** `miso` = 0, all strobes = 0, `wrtdata` = 0x00, state IDLE, counter 0, shift registers 0.
- **Synchroniser latency:** 2 clocks, plus 1 clock for edge detection.
- **Write latency:** the strobe is asserted 1 clock after the clock in which the 16th rising edge is detected, i.e. 4 clocks after the raw `sclk` edge (±1 for sampling phase).
- **`miso` latency:** updates 1 clock after the detected falling edge (or the 8th rising edge for the load), i.e. at most 4 clocks after the raw edge.
- **SCLK limits:** high and low phases must each be ≥ 4 `clk` periods, i.e. SCLK ≤ `clk`/8.
- **`ssn` setup/hold:** ≥ 4 `clk` periods before the first and after the last SCLK edge.
- **Strobe timing:** strobes never occur in consecutive clocks. The minimum spacing is one full frame.

## Test plan
- **Reset values:** hold `resetn` low, toggle SCLK and MOSI → all outputs 0, `wrtdata` = 0x00; after release, no strobe without a complete frame.
- **Config write:** write frame 0x01, 0xA5 → a single one-clock `cfgld1` pulse with `wrtdata` = 0xA5 ≈4 clocks after the 16th edge; no other strobe; `wrtdata` stays 0xA5 afterwards.
- **Control read:** read frame 0x83 with `controlrdata` = 0x88 → the host samples 0x88 MSB-first on rising edges 9–16; `miso` = 0 in DONE and IDLE. Changing `controlrdata` to 0x00 after edge 8 must not alter the shifted value.
- **Abort:** raise `ssn` after 12 SCLK edges of write frame 0x00, 0xFF → no `cfgld0`, state IDLE. A following full write 0x04, 0x10 pulses `wdogdivld` with 0x10.
- **Watchdog kick and unmapped address:** write 0x06, 0x00 → one `wdreset` pulse. Write 0x0F, 0x55 → no strobes. Read 0x85 → `hwconfig` value (0x30). Read 0x87 → 0x00.
- **Extra edges and reset mid-frame:** 20 SCLK edges on write 0x00, 0x12 → exactly one `cfgld0`. Assert `resetn` at edge 10 of a write → no strobe, all outputs 0.
